// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter: increment, redirects, traps, fetch bubble
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(4),
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch,
  input  logic [XLEN-1:0] addr,
  input  logic            trap,
  input  logic            trap_ret,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] epc,
  output logic            misalign
);

  typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;

  localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

  if (XLEN < 8 || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_params
    $error("pc_unit: unsupported XLEN or RAS_DEPTH");
  end

  state_t          state, next_state;
  logic [XLEN-1:0] pc_upd, epc_upd, target;
  logic            mis_upd;
  logic            redirect_req;

  assign redirect_req = trap_ret | ret | call | branch;

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr, ras_top;
  logic [PTR_W:0]   ras_count;
  logic             push, pop;

  assign ras_top = ras_ptr - 1'b1;

  // Circular stack: pushing when full lands on the oldest slot and overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (push) begin
      ras_mem[ras_ptr] <= pc + INC_V;
      ras_ptr          <= ras_ptr + 1'b1;
      if (ras_count != (PTR_W + 1)'(RAS_DEPTH))
        ras_count <= ras_count + 1'b1;
    end else if (pop && ras_count != '0) begin
      ras_ptr   <= ras_top;
      ras_count <= ras_count - 1'b1;
    end
  end
`endif

  always_comb begin
    target     = addr;
    pc_upd     = pc;
    epc_upd    = epc;
    mis_upd    = 1'b0;
    next_state = RUN;
`ifdef PC_RAS_EN
    push = 1'b0;
    pop  = 1'b0;
`endif

    // Only the highest-priority redirect's target is checked for alignment.
    if (trap_ret)
      target = epc;
`ifdef PC_RAS_EN
    else if (ret && ras_count != '0)
      target = ras_mem[ras_top];
`endif

    if (trap) begin
      pc_upd     = TRAP_VEC;
      epc_upd    = pc;
      next_state = BUBBLE;
    end else if (redirect_req && target[1:0] != 2'b00) begin
      pc_upd     = TRAP_VEC;
      epc_upd    = pc;
      mis_upd    = 1'b1;
      next_state = BUBBLE;
    end else if (redirect_req) begin
      pc_upd     = target;
      next_state = BUBBLE;
`ifdef PC_RAS_EN
      pop  = ret & ~trap_ret;
      push = call & ~trap_ret & ~ret;
`endif
    end else if (state == RUN && !stall) begin
      pc_upd = pc + INC_V;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_VEC;
      epc      <= '0;
      misalign <= 1'b0;
      pc_valid <= 1'b0;
    end else begin
      state    <= next_state;
      pc       <= pc_upd;
      epc      <= epc_upd;
      misalign <= mis_upd;
      pc_valid <= (next_state == RUN);
    end
  end

  assign pc_next = rst ? RESET_VEC : pc_upd;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed table, hand sequences and random reference-model check of pc_unit
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch, trap, trap_ret, call, ret;
  logic [31:0] addr;
  logic [31:0] pc, pc_next, epc;
  logic        pc_valid, misalign;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .addr(addr),
    .trap(trap), .trap_ret(trap_ret), .call(call), .ret(ret),
    .pc(pc), .pc_valid(pc_valid), .pc_next(pc_next), .epc(epc), .misalign(misalign)
  );

  typedef struct {
    logic        r, s, b;
    logic [31:0] a;
    logic        t, tr;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_epc;
    logic        e_m;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_valid, m_mis;
  logic [31:0] ras_q[$];

  function automatic vec_t mk(input logic r, s, b, input logic [31:0] a, input logic t, tr,
                              input logic [31:0] e_pc, input logic e_v,
                              input logic [31:0] e_epc, input logic e_m);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.a = a; v.t = t; v.tr = tr;
    v.e_pc = e_pc; v.e_v = e_v; v.e_epc = e_epc; v.e_m = e_m;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic r, s, b, input logic [31:0] a, input logic t, tr, c, rt);
    rst = r; stall = s; branch = b; addr = a; trap = t; trap_ret = tr; call = c; ret = rt;
  endtask

  task automatic cycle_check(input string nm, input logic [31:0] e_pc, input logic e_v,
                             input logic [31:0] e_epc, input logic e_m);
    #2;
    chk({nm, " pc_next"}, pc_next, e_pc);
    @(posedge clk);
    #1;
    chk({nm, " pc"}, pc, e_pc);
    chk({nm, " pc_valid"}, {31'b0, pc_valid}, {31'b0, e_v});
    chk({nm, " epc"}, epc, e_epc);
    chk({nm, " misalign"}, {31'b0, misalign}, {31'b0, e_m});
  endtask

  // Behavioural model: one call = one clock edge with the given request inputs.
  task automatic model_step(input logic r, s, b, input logic [31:0] a, input logic t, tr, c, rt);
    logic [31:0] tgt;
    logic        redirect;
    redirect = 1'b1;
    m_mis    = 1'b0;
    if (r) begin
      m_pc = 32'h0; m_epc = 32'h0; m_valid = 1'b0; redirect = 1'b0;
      ras_q.delete();
    end else if (t) begin
      m_epc = m_pc; m_pc = 32'h4;
    end else if (tr || rt || c || b) begin
      tgt = a;
      if (tr) tgt = m_epc;
`ifdef PC_RAS_EN
      else if (rt && ras_q.size() > 0) tgt = ras_q[$];
`endif
      if (tgt % 4 != 0) begin
        m_epc = m_pc; m_pc = 32'h4; m_mis = 1'b1;
      end else begin
`ifdef PC_RAS_EN
        if (!tr && rt && ras_q.size() > 0) void'(ras_q.pop_back());
        else if (!tr && !rt && c) begin
          ras_q.push_back(m_pc + 32'd4);
          if (ras_q.size() > 4) void'(ras_q.pop_front());
        end
`endif
        m_pc = tgt;
      end
    end else begin
      redirect = 1'b0;
      if (m_valid && !s) m_pc = m_pc + 32'd4;
    end
    if (!r) m_valid = !redirect;
  endtask

  initial begin
    logic [31:0] e_ret [5];
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // directed table from reset through stall, bubble, misalign, trap and wrap
    vecs.push_back(mk(1,0,0,32'h0,0,0, 32'h0,0,32'h0,0));
    vecs.push_back(mk(1,0,0,32'h0,0,0, 32'h0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h0,1,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h4,1,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h8,1,32'h0,0));
    vecs.push_back(mk(0,1,0,32'h0,0,0, 32'h8,1,32'h0,0));
    vecs.push_back(mk(0,1,0,32'h0,0,0, 32'h8,1,32'h0,0));
    vecs.push_back(mk(0,1,0,32'h0,0,0, 32'h8,1,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'hC,1,32'h0,0));
    vecs.push_back(mk(0,1,1,32'h1234,0,0, 32'h1234,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h1234,1,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h1238,1,32'h0,0));
    vecs.push_back(mk(0,0,1,32'h20,0,0, 32'h20,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h20,1,32'h0,0));
    vecs.push_back(mk(0,0,1,32'h1236,0,0, 32'h4,0,32'h20,1));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h4,1,32'h20,0));
    vecs.push_back(mk(0,0,0,32'h0,0,1, 32'h20,0,32'h20,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h20,1,32'h20,0));
    vecs.push_back(mk(0,0,1,32'h40,0,0, 32'h40,0,32'h20,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h40,1,32'h20,0));
    vecs.push_back(mk(0,0,1,32'h80,1,0, 32'h4,0,32'h40,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h4,1,32'h40,0));
    vecs.push_back(mk(0,0,1,32'hFFFF_FFF8,0,0, 32'hFFFF_FFF8,0,32'h40,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'hFFFF_FFF8,1,32'h40,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'hFFFF_FFFC,1,32'h40,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h0,1,32'h40,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h4,1,32'h40,0));
    vecs.push_back(mk(1,1,1,32'h100,0,0, 32'h0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h0,1,32'h0,0));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].a, vecs[i].t, vecs[i].tr, 0, 0);
      cycle_check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_v, vecs[i].e_epc, vecs[i].e_m);
    end

    // call / ret sequence: stack returns with PC_RAS_EN, plain redirects otherwise
`ifdef PC_RAS_EN
    e_ret = '{32'h804, 32'h604, 32'h404, 32'h204, 32'hA00};
`else
    e_ret = '{32'hA00, 32'hA00, 32'hA00, 32'hA00, 32'hA00};
`endif
    drive(0, 0, 1, 32'h10, 0, 0, 0, 0); cycle_check("goto10", 32'h10, 0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0, 0, 0, 0);  cycle_check("run10", 32'h10, 1, 32'h0, 0);
    drive(0, 0, 0, 32'h100, 0, 0, 1, 0); cycle_check("call100", 32'h100, 0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0, 0, 0, 0);  cycle_check("run100", 32'h100, 1, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0, 0, 0, 0);  cycle_check("run104", 32'h104, 1, 32'h0, 0);
`ifdef PC_RAS_EN
    drive(0, 0, 0, 32'h900, 0, 0, 0, 1); cycle_check("ret1", 32'h14, 0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0, 0, 0, 0);  cycle_check("ret1run", 32'h14, 1, 32'h0, 0);
`else
    drive(0, 0, 0, 32'h900, 0, 0, 0, 1); cycle_check("ret1", 32'h900, 0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0, 0, 0, 0);  cycle_check("ret1run", 32'h900, 1, 32'h0, 0);
`endif
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0, 32'h200 * k, 0, 0, 1, 0);
      cycle_check($sformatf("ncall%0d", k), 32'h200 * k, 0, 32'h0, 0);
      drive(0, 0, 0, 32'h0, 0, 0, 0, 0);
      cycle_check($sformatf("ncall%0d run", k), 32'h200 * k, 1, 32'h0, 0);
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 32'hA00, 0, 0, 0, 1);
      cycle_check($sformatf("nret%0d", k), e_ret[k], 0, 32'h0, 0);
      drive(0, 0, 0, 32'h0, 0, 0, 0, 0);
      cycle_check($sformatf("nret%0d run", k), e_ret[k], 1, 32'h0, 0);
    end

    // randomized run against the reference model
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0, 0);
    cycle_check("rnd_reset", m_pc, m_valid, m_epc, m_mis);
    for (int n = 0; n < 2000; n++) begin
      logic        r, s, b, t, tr, c, rt;
      logic [31:0] a;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 19) == 0);
      tr = ($urandom_range(0, 19) == 0);
      c  = ($urandom_range(0, 9) == 0);
      rt = ($urandom_range(0, 9) == 0);
      a  = $urandom;
      if ($urandom_range(0, 7) != 0) a = a & 32'hFFFF_FFFC;
      drive(r, s, b, a, t, tr, c, rt);
      model_step(r, s, b, a, t, tr, c, rt);
      cycle_check($sformatf("rnd%0d", n), m_pc, m_valid, m_epc, m_mis);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the single-width branch/increment PC register.
- Sits at the head of the fetch stage and drives the instruction-memory address.
- Adds sequential increment with stall, branch redirect, trap entry and return with a saved EPC, and misaligned-target trapping.
- Provides a one-cycle fetch-valid bubble after every redirect, and an optional return-address stack.

Parameters:
XLEN, 32, PC/address width in bits (min 8)
RESET_VEC, 32'h0000_0000, PC value loaded on reset (XLEN bits)
TRAP_VEC, 32'h0000_0004, PC value loaded on trap entry (XLEN bits)
INC, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2); used only with PC_RAS_EN

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold PC (no increment) when no redirect is requested
branch  in  1  redirect request to addr
addr  in  XLEN  branch/call target
trap  in  1  trap entry request
trap_ret  in  1  return from trap to epc
call  in  1  call redirect to addr (RAS push with PC_RAS_EN)
ret  in  1  return redirect (RAS pop with PC_RAS_EN)
pc  out  XLEN  current fetch address (registered)
pc_valid  out  1  pc is a valid fetch this cycle
pc_next  out  XLEN  combinational value pc will take at next edge
epc  out  XLEN  saved exception PC (registered)
misalign  out  1  registered pulse: last redirect target was misaligned

Behaviour:
- Reset: rst is synchronous and active-high. On an edge with rst=1: pc<=RESET_VEC, epc<=0, misalign<=0, pc_valid<=0, RAS emptied. rst overrides all other inputs. Reset mid-operation discards any pending request.
- State machine: BOOT, RUN, BUBBLE.
  - BOOT: entered on reset. pc_valid=0. Next state is RUN (no increment on that edge).
  - RUN: pc_valid=1.
  - BUBBLE: entered on any redirect. pc_valid=0 for exactly one cycle, then RUN. pc holds the redirect target during BUBBLE and is not incremented.
- Next-PC priority, highest first:
  1. rst
  2. trap: pc<=TRAP_VEC, epc<=pc
  3. misaligned redirect (branch/call with addr[1:0]!=0, or ret/trap_ret target[1:0]!=0): pc<=TRAP_VEC, epc<=pc, misalign<=1 for one cycle
  4. trap_ret: pc<=epc
  5. ret
  6. call
  7. branch: pc<=addr
  8. stall: hold
  9. otherwise in RUN: pc<=pc+INC
- Redirects take effect even when stall=1. stall only blocks increment.
- Simultaneous requests: only the highest-priority one acts; the others are dropped, not queued.
- Arithmetic: pc+INC is modulo 2^XLEN and wraps silently, e.g. pc=32'hFFFF_FFFC → 32'h0000_0000.
- pc_next always equals the value pc takes at the next edge, including the reset case.
- misalign is 0 in every cycle except the one following a misaligned redirect.

Optional Feature:
PC_RAS_EN
- Defined: RAS_DEPTH-entry circular return-address stack.
  - call pushes pc+INC and redirects to addr.
  - ret pops and redirects to the popped value; addr is ignored.
  - Push when full overwrites the oldest entry; the count saturates at RAS_DEPTH.
  - ret when empty redirects to addr.
  - trap and rst leave entries untouched and clear them, respectively.
- Undefined: no stack storage. call behaves as branch; ret behaves as branch (to addr). Ports remain present.

Test Plan:
- rst=1 for 2 cycles, then 0 → pc=0, pc_valid=0 for one cycle after release, then pc=0,4,8,12 with pc_valid=1.
- At pc=8 assert stall for 3 cycles → pc holds 8; release → 12. Assert stall+branch addr=32'h1234 together → pc=32'h1234 next cycle, pc_valid=0 one cycle, then 32'h1238.
- branch addr=32'h1236 at pc=32'h20 → pc=TRAP_VEC=4, epc=32'h20, misalign=1 for one cycle. Then trap_ret → pc=32'h20.
- trap and branch same cycle at pc=32'h40 → pc=4, epc=32'h40, branch dropped.
- XLEN=32, pc forced near top via branch 32'hFFFF_FFF8 → 32'hFFFF_FFFC → 32'h0000_0000.
- PC_RAS_EN, RAS_DEPTH=4:
  - call addr=32'h100 at pc=32'h10 → pc=32'h100. Later ret → pc=32'h14.
  - 5 nested calls then 5 rets → first 4 rets return the newest 4 addresses; 5th ret falls back to addr.
  - Without the macro, the same call/ret sequence → pc=addr each time.
